// File: rtl/adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture_ctrl
// Purpose  : AXI-Lite controlled ADC sample capture engine. A programmable
//            divider produces sample ticks while capturing. Each tick pushes
//            the registered ADC sample into a FIFO, which is drained through
//            the DATA register. Single-shot and continuous modes are
//            supported, with sticky done/overflow flags driving a level irq.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, aresetn            : system clock (rising edge); async active-low reset
//   s_axi_aw_* / s_axi_w_*  : AXI-Lite write address / data channels
//   s_axi_b_*               : AXI-Lite write response channel (always OKAY)
//   s_axi_ar_* / s_axi_r_*  : AXI-Lite read address / data channels (OKAY)
//   adc_ch1_data            : raw 12-bit ADC sample input
//   adc_ch1_clk             : ADC conversion clock (forwarded clk)
//   busy                    : capture in progress
//   irq                     : done OR overflow (level)
// Register map (word index)
//   0 CTRL   : W bit0 START, bit1 ABORT (pulses), bit2 CONT; R {CONT,2'b00}
//   1 DIV    : tick period minus one
//   2 COUNT  : samples per capture
//   3 STATUS : bit0 busy, bit1 done, bit2 overflow, [8:4] FIFO level
//   4 DATA   : {valid, 19'd0, sample[11:0]}; popping read
// ============================================================================
module adc_capture_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    aresetn,
  // AXI-Lite write slave
  input  logic                    s_axi_aw_valid,
  output logic                    s_axi_aw_ready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_aw_addr,
  input  logic [2:0]              s_axi_aw_prot,
  input  logic                    s_axi_w_valid,
  output logic                    s_axi_w_ready,
  input  logic [DATA_WIDTH-1:0]   s_axi_w_data,
  input  logic [DATA_WIDTH/8-1:0] s_axi_w_strb,
  output logic                    s_axi_b_valid,
  input  logic                    s_axi_b_ready,
  output logic [1:0]              s_axi_b_resp,
  // AXI-Lite read slave
  input  logic                    s_axi_ar_valid,
  output logic                    s_axi_ar_ready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_ar_addr,
  input  logic [2:0]              s_axi_ar_prot,
  output logic                    s_axi_r_valid,
  input  logic                    s_axi_r_ready,
  output logic [DATA_WIDTH-1:0]   s_axi_r_data,
  output logic [1:0]              s_axi_r_resp,
  // ADC side
  input  logic [11:0]             adc_ch1_data,
  output logic                    adc_ch1_clk,
  // Status
  output logic                    busy,
  output logic                    irq
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_LVL_W = c_PTR_W + 1;

  localparam logic [ADDR_WIDTH-1:0] c_ADDR_CTRL   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_DIV    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_COUNT  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_STATUS = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_DATA   = ADDR_WIDTH'(4);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Configuration and status registers
  logic [15:0] r_div;
  logic [15:0] r_count;
  logic        r_cont;
  logic        r_done;
  logic        r_ovf;
  logic [15:0] r_timer;
  logic [15:0] r_remaining;
  logic [11:0] r_adc_q;

  // AXI channel state
  logic                  r_b_valid;
  logic                  r_r_valid;
  logic [DATA_WIDTH-1:0] r_r_data;

  // Sample FIFO: pointers carry one extra bit so full and empty differ
  logic [11:0]        r_mem [FIFO_DEPTH];
  logic [c_LVL_W-1:0] r_wptr;
  logic [c_LVL_W-1:0] r_rptr;
  logic [c_LVL_W-1:0] w_level;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  // Decoded bus events
  logic                  w_wr_en;
  logic                  w_start;
  logic                  w_abort;
  logic                  w_ar_hs;
  logic [DATA_WIDTH-1:0] w_rdata;

  // FSM-derived control strobes
  logic w_start_run;
  logic w_zero_start;
  logic w_tick;
  logic w_finish;
  logic w_reload_rem;

  // Inputs with no function in this block, gathered to show intent
  logic w_unused;
  assign w_unused = ^{s_axi_aw_prot, s_axi_ar_prot, s_axi_w_strb,
                      s_axi_w_data[DATA_WIDTH-1:16]};

  assign adc_ch1_clk = clk;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  // A write commits only when address and data arrive in the same cycle.
  assign w_wr_en = s_axi_aw_valid && s_axi_w_valid && !r_b_valid;
  assign w_start = w_wr_en && (s_axi_aw_addr == c_ADDR_CTRL) && s_axi_w_data[0];
  assign w_abort = w_wr_en && (s_axi_aw_addr == c_ADDR_CTRL) && s_axi_w_data[1];
  assign w_ar_hs = s_axi_ar_valid && !r_r_valid;

  assign w_level = r_wptr - r_rptr;
  assign w_full  = (w_level == c_LVL_W'(FIFO_DEPTH));
  assign w_empty = (w_level == '0);
  assign w_pop   = w_ar_hs && (s_axi_ar_addr == c_ADDR_DATA) && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push  = w_tick && (!w_full || w_pop);

  // --------------------------------------------------------------------------
  // Capture FSM: next state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_start_run  = 1'b0;
    w_zero_start = 1'b0;
    w_tick       = 1'b0;
    w_finish     = 1'b0;
    w_reload_rem = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start && !w_abort) begin
          if (r_count != 16'd0) begin
            w_state_nxt = RUN;
            w_start_run = 1'b1;
          end else begin
            w_zero_start = 1'b1;
          end
        end
      end
      RUN: begin
        if (w_abort) begin
          w_state_nxt = IDLE;
        end else if (r_timer == 16'd0) begin
          w_tick = 1'b1;
          // remaining <= 1 also covers a COUNT of zero picked up on reload
          if (r_remaining <= 16'd1) begin
            if (r_cont) begin
              w_reload_rem = 1'b1;
            end else begin
              w_finish    = 1'b1;
              w_state_nxt = IDLE;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Configuration, timer, counters, flags and FIFO pointers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_div       <= '0;
      r_count     <= '0;
      r_cont      <= 1'b0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
      r_timer     <= '0;
      r_remaining <= '0;
      r_adc_q     <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
    end else begin
      r_adc_q <= adc_ch1_data;

      if (w_wr_en) begin
        case (s_axi_aw_addr)
          c_ADDR_CTRL:  r_cont  <= s_axi_w_data[2];
          c_ADDR_DIV:   r_div   <= s_axi_w_data[15:0];
          c_ADDR_COUNT: r_count <= s_axi_w_data[15:0];
          default: ;
        endcase
      end

      // DIV/COUNT are only sampled here, so writes during RUN wait for reload.
      if (w_start_run) begin
        r_timer     <= r_div;
        r_remaining <= r_count;
      end else if ((r_state == RUN) && !w_abort) begin
        if (w_tick) begin
          r_timer <= r_div;
          if (w_reload_rem) begin
            r_remaining <= r_count;
          end else if (w_finish) begin
            r_remaining <= '0;
          end else begin
            r_remaining <= r_remaining - 16'd1;
          end
        end else begin
          r_timer <= r_timer - 16'd1;
        end
      end

      if (w_start_run) begin
        r_done <= 1'b0;
        r_ovf  <= 1'b0;
      end else if (w_zero_start) begin
        r_done <= 1'b1;
        r_ovf  <= 1'b0;
      end else begin
        if (w_finish) begin
          r_done <= 1'b1;
        end
        if (w_tick && !w_push) begin
          r_ovf <= 1'b1;
        end
      end

      if (w_start_run) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + 1'b1;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + 1'b1;
        end
      end
    end
  end

  // Sample storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[c_PTR_W-1:0]] <= r_adc_q;
    end
  end

  // --------------------------------------------------------------------------
  // AXI-Lite channels
  // --------------------------------------------------------------------------
  always_comb begin
    w_rdata = '0;
    case (s_axi_ar_addr)
      c_ADDR_CTRL:   w_rdata[2]     = r_cont;
      c_ADDR_DIV:    w_rdata[15:0]  = r_div;
      c_ADDR_COUNT:  w_rdata[15:0]  = r_count;
      c_ADDR_STATUS: begin
        w_rdata[0]           = (r_state == RUN);
        w_rdata[1]           = r_done;
        w_rdata[2]           = r_ovf;
        w_rdata[4 +: c_LVL_W] = w_level;
      end
      c_ADDR_DATA: begin
        if (!w_empty) begin
          w_rdata[DATA_WIDTH-1] = 1'b1;
          w_rdata[11:0]         = r_mem[r_rptr[c_PTR_W-1:0]];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_b_valid <= 1'b0;
      r_r_valid <= 1'b0;
      r_r_data  <= '0;
    end else begin
      if (w_wr_en) begin
        r_b_valid <= 1'b1;
      end else if (s_axi_b_ready) begin
        r_b_valid <= 1'b0;
      end

      if (w_ar_hs) begin
        r_r_valid <= 1'b1;
        r_r_data  <= w_rdata;
      end else if (s_axi_r_ready) begin
        r_r_valid <= 1'b0;
      end
    end
  end

  assign s_axi_aw_ready = !r_b_valid;
  assign s_axi_w_ready  = !r_b_valid;
  assign s_axi_b_valid  = r_b_valid;
  assign s_axi_b_resp   = 2'b00;
  assign s_axi_ar_ready = !r_r_valid;
  assign s_axi_r_valid  = r_r_valid;
  assign s_axi_r_data   = r_r_data;
  assign s_axi_r_resp   = 2'b00;

  assign busy = (r_state == RUN);
  assign irq  = r_done | r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_capture_ctrl
// Purpose  : Self-checking bench for adc_capture_ctrl. The ADC input is a
//            ramp tied to a bench edge counter, so the expected content of
//            every FIFO entry follows from the tick schedule alone.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_capture_ctrl;

  localparam int c_DEPTH = 16;

  logic        clk = 1'b0;
  logic        aresetn = 1'b1;
  logic        aw_valid = 1'b0;
  logic        aw_ready;
  logic [3:0]  aw_addr = '0;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [31:0] w_data = '0;
  logic        b_valid;
  logic        b_ready = 1'b1;
  logic [1:0]  b_resp;
  logic        ar_valid = 1'b0;
  logic        ar_ready;
  logic [3:0]  ar_addr = '0;
  logic        r_valid;
  logic        r_ready = 1'b1;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic [11:0] adc_ch1_data = '0;
  logic        adc_ch1_clk;
  logic        busy;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  int adc_ofs  = 0;
  int last_hs_edge = 0;

  typedef struct {
    int          div;
    int          count;
    logic [31:0] exp_status;
  } vec_t;

  adc_capture_ctrl #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(4),
    .FIFO_DEPTH(c_DEPTH)
  ) dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .s_axi_aw_valid (aw_valid),
    .s_axi_aw_ready (aw_ready),
    .s_axi_aw_addr  (aw_addr),
    .s_axi_aw_prot  (3'b000),
    .s_axi_w_valid  (w_valid),
    .s_axi_w_ready  (w_ready),
    .s_axi_w_data   (w_data),
    .s_axi_w_strb   (4'hF),
    .s_axi_b_valid  (b_valid),
    .s_axi_b_ready  (b_ready),
    .s_axi_b_resp   (b_resp),
    .s_axi_ar_valid (ar_valid),
    .s_axi_ar_ready (ar_ready),
    .s_axi_ar_addr  (ar_addr),
    .s_axi_ar_prot  (3'b000),
    .s_axi_r_valid  (r_valid),
    .s_axi_r_ready  (r_ready),
    .s_axi_r_data   (r_data),
    .s_axi_r_resp   (r_resp),
    .adc_ch1_data   (adc_ch1_data),
    .adc_ch1_clk    (adc_ch1_clk),
    .busy           (busy),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  // edge_cnt = number of rising edges seen; the ramp value present during the
  // cycle after edge k is g(k), so the DUT registers g(k) at edge k+1.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;
  always @(negedge clk) adc_ch1_data = 12'(adc_ofs + edge_cnt);

  function automatic logic [11:0] g(input int k);
    return 12'(adc_ofs + k);
  endfunction

  // Expected DATA word for the j-th tick of a capture started at edge s:
  // tick edge t = s + (div+1)*j pushes the sample registered at t-1, i.e. g(t-2).
  function automatic logic [31:0] exp_sample(input int s, input int div, input int j);
    return {1'b1, 19'd0, g(s + (div + 1) * j - 2)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic axi_write(input int a, input int d);
    int n;
    n = 0;
    @(negedge clk);
    aw_valid = 1'b1;
    w_valid  = 1'b1;
    aw_addr  = 4'(a);
    w_data   = 32'(d);
    while (!aw_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("aw_ready before write", 32'(aw_ready), 32'd1);
    @(posedge clk);
    last_hs_edge = edge_cnt + 1;
    #1;
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    chk("b_valid after write", 32'({b_valid, b_resp}), 32'h4);
  endtask

  task automatic axi_read(input int a, output logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    ar_valid = 1'b1;
    ar_addr  = 4'(a);
    while (!ar_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ar_ready before read", 32'(ar_ready), 32'd1);
    @(posedge clk);
    #1;
    ar_valid = 1'b0;
    chk("r_valid after read", 32'({r_valid, r_resp}), 32'h4);
    d = r_data;
  endtask

  // Checks that busy is still high after edge e-1 and low after edge e.
  task automatic check_done_at(input int e, input string tag);
    do @(negedge clk); while (edge_cnt < e - 1);
    chk({tag, " busy before last tick"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({tag, " busy after last tick"}, 32'(busy), 32'd0);
    chk({tag, " irq"}, 32'(irq), 32'd1);
  endtask

  task automatic run_capture(input int div, input int count,
                             input logic [31:0] exp_status, input string tag);
    logic [31:0] d;
    int s;
    int n;
    adc_ofs = int'($urandom_range(0, 4095));
    axi_write(1, div);
    axi_write(2, count);
    axi_write(0, 1);
    s = last_hs_edge;
    check_done_at(s + (div + 1) * count, tag);
    axi_read(3, d);
    chk({tag, " STATUS"}, d, exp_status);
    n = (count < c_DEPTH) ? count : c_DEPTH;
    for (int j = 1; j <= n; j++) begin
      axi_read(4, d);
      chk({tag, " DATA"}, d, exp_sample(s, div, j));
    end
    axi_read(4, d);
    chk({tag, " DATA when empty"}, d, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[5];
    logic [31:0] d;
    int          s;
    int          div;
    int          count;
    int          lvl;

    vecs[0] = '{div: 3, count: 4,  exp_status: 32'h0000_0042};
    vecs[1] = '{div: 1, count: 16, exp_status: 32'h0000_0102};
    vecs[2] = '{div: 2, count: 17, exp_status: 32'h0000_0106};
    vecs[3] = '{div: 0, count: 1,  exp_status: 32'h0000_0012};
    vecs[4] = '{div: 0, count: 20, exp_status: 32'h0000_0106};

    // Reset state
    #2 aresetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset ready flags", 32'({aw_ready, w_ready, ar_ready}), 32'h7);
    chk("reset valid flags", 32'({b_valid, r_valid}), 32'h0);
    chk("reset r_data", r_data, 32'h0);
    chk("reset busy/irq", 32'({busy, irq}), 32'h0);
    aresetn = 1'b1;

    for (int a = 0; a < 8; a++) begin
      axi_read(a, d);
      chk("register after reset", d, 32'h0);
    end

    // Register map
    axi_write(1, 32'hABCD_1234);
    axi_write(2, 32'h5678_9ABC);
    axi_write(0, 4);
    axi_write(5, 32'hFFFF_FFFF);
    axi_read(1, d);  chk("DIV readback", d, 32'h0000_1234);
    axi_read(2, d);  chk("COUNT readback", d, 32'h0000_9ABC);
    axi_read(0, d);  chk("CTRL readback", d, 32'h0000_0004);
    axi_read(5, d);  chk("unmapped readback", d, 32'h0);
    chk("idle busy", 32'(busy), 32'd0);
    axi_write(0, 0);

    // Table-driven single-shot captures
    foreach (vecs[i]) begin
      run_capture(vecs[i].div, vecs[i].count, vecs[i].exp_status, "vec");
    end

    // START with COUNT=0: done without running; previous overflow cleared
    axi_write(2, 0);
    axi_write(0, 1);
    chk("zero-count busy", 32'(busy), 32'd0);
    axi_read(3, d);
    chk("zero-count STATUS", d, 32'h0000_0002);

    // Continuous mode keeps running, then ABORT
    axi_write(1, 1);
    axi_write(2, 2);
    axi_write(0, 5);
    s = last_hs_edge;
    do @(negedge clk); while (edge_cnt < s + 12);
    chk("cont busy after 6 ticks", 32'(busy), 32'd1);
    axi_read(0, d);
    chk("cont CTRL", d, 32'h0000_0004);
    axi_write(0, 2);
    chk("abort busy", 32'(busy), 32'd0);
    axi_read(3, d);
    chk("abort STATUS flags", d & 32'h7, 32'h0);
    chk("abort kept samples", 32'(d[8:4] != 5'd0), 32'd1);
    for (int i = 0; i < 20; i++) begin
      axi_read(4, d);
      if (d == 32'd0) break;
    end
    axi_read(3, d);
    chk("drained STATUS", d, 32'h0);

    // START while running does not restart the capture
    axi_write(1, 2);
    axi_write(2, 4);
    axi_write(0, 1);
    s = last_hs_edge;
    axi_write(0, 1);
    check_done_at(s + 12, "restart");
    axi_read(3, d);
    chk("restart STATUS", d, 32'h0000_0042);

    // Back-to-back DATA reads with a stalled R channel
    adc_ofs = int'($urandom_range(0, 4095));
    axi_write(1, 0);
    axi_write(2, 3);
    axi_write(0, 1);
    s = last_hs_edge;
    repeat (6) @(negedge clk);
    r_ready  = 1'b0;
    ar_valid = 1'b1;
    ar_addr  = 4'd4;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall ar_ready", 32'(ar_ready), 32'd0);
      chk("stall r_valid", 32'(r_valid), 32'd1);
    end
    chk("stall first DATA", r_data, exp_sample(s, 0, 1));
    r_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("accept r_valid", 32'(r_valid), 32'd0);
    chk("accept ar_ready", 32'(ar_ready), 32'd1);
    @(posedge clk);
    #1;
    ar_valid = 1'b0;
    chk("second r_valid", 32'(r_valid), 32'd1);
    chk("second DATA", r_data, exp_sample(s, 0, 2));
    axi_read(3, d);
    chk("one pop per read STATUS", d, 32'h0000_0012);

    // Randomized single-shot captures against the schedule model
    for (int it = 0; it < 6; it++) begin
      div   = int'($urandom_range(0, 4));
      count = int'($urandom_range(1, 22));
      lvl   = (count < c_DEPTH) ? count : c_DEPTH;
      run_capture(div, count,
                  32'((lvl << 4) | ((count > c_DEPTH) ? 4 : 0) | 2), "random");
    end

    // Asynchronous reset in the middle of a capture with 5 samples stored
    axi_write(1, 0);
    axi_write(2, 12);
    axi_write(0, 5);
    s = last_hs_edge;
    do @(negedge clk); while (edge_cnt < s + 5);
    chk("pre-reset busy", 32'(busy), 32'd1);
    aresetn = 1'b0;
    #1;
    chk("mid-run reset busy/irq", 32'({busy, irq}), 32'h0);
    chk("mid-run reset ready flags", 32'({aw_ready, w_ready, ar_ready}), 32'h7);
    chk("mid-run reset valid flags", 32'({b_valid, r_valid}), 32'h0);
    chk("mid-run reset r_data", r_data, 32'h0);
    @(negedge clk);
    aresetn = 1'b1;
    for (int a = 0; a < 4; a++) begin
      axi_read(a, d);
      chk("register after mid-run reset", d, 32'h0);
    end
    axi_read(4, d);
    chk("DATA after mid-run reset", d, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
